// File: rtl/axis_addr_split_pkg.sv
// Shared types and helpers for the axis address-channel burst splitter.
package axis_addr_split_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_CALC  = 5'b00010,
        ST_ISSUE = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [63:0] min_u64(input logic [63:0] a, input logic [63:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_addr_split_credit_cnt.sv
// Saturating up/down counter of issued-but-unretired bursts.
module axis_credit_cnt
    import axis_addr_split_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int unsigned CNT_W = clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != CNT_W'(MAX_COUNT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full  = (cnt_q == CNT_W'(MAX_COUNT));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/axis_addr_split.sv
// Splits one {address, beat-length} command into AXI address bursts capped at
// MAX_BURST beats, never crossing a BOUNDARY-byte line, with outstanding-burst credits.
module axis_addr_split
    import axis_addr_split_pkg::*;
#(
    parameter int unsigned CFG_DWIDTH      = 32,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_LEN_WIDTH   = 8,
    parameter int unsigned AXI_DATA_WIDTH  = 256,
    parameter int unsigned MAX_BURST       = 256,
    parameter int unsigned BOUNDARY        = 4096,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CFG_DWIDTH-1:0]     cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      axi_aready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_alen,
    output logic                      axi_avalid,
    input  logic                      burst_retire,
    output logic                      cmd_done,
    output logic                      busy
);

    localparam int unsigned BYTES     = AXI_DATA_WIDTH / 8;
    localparam int unsigned BYTES_LOG = clog2(BYTES);
    localparam int unsigned BND_LOG   = clog2(BOUNDARY);
    localparam int unsigned CHUNK_W   = AXI_LEN_WIDTH + 1;
    localparam logic [BND_LOG:0] BND_FULL = (BND_LOG + 1)'(BOUNDARY);

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CFG_DWIDTH-1:0]     remaining_q, remaining_d;
    logic [AXI_LEN_WIDTH-1:0]  alen_q, alen_d;
    logic [BND_LOG:0]          bnd_bytes, to_bnd;
    logic [CHUNK_W-1:0]        chunk_calc, chunk_iss;
    logic                      credit_full, credit_empty, handshake;

    // Beats left before the next BOUNDARY line, from the low address bits.
    assign bnd_bytes  = BND_FULL - {1'b0, addr_q[BND_LOG-1:0]};
    assign to_bnd     = bnd_bytes >> BYTES_LOG;
    assign chunk_calc = CHUNK_W'(min_u64(min_u64(64'(remaining_q), 64'(MAX_BURST)), 64'(to_bnd)));
    // The issued chunk is recovered from alen_q so that the reset value of axi_alen is 0.
    assign chunk_iss  = {1'b0, alen_q} + CHUNK_W'(1);

    assign axi_avalid = (state_q == ST_ISSUE) && !credit_full;
    assign handshake  = axi_avalid && axi_aready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        alen_d      = alen_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    addr_d      = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BYTES - 1);
                    remaining_d = cfg_length;
                    state_d     = (cfg_length == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                alen_d  = AXI_LEN_WIDTH'(chunk_calc - CHUNK_W'(1));
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (handshake) begin
                    addr_d      = addr_q + (AXI_ADDR_WIDTH'(chunk_iss) << BYTES_LOG);
                    remaining_d = remaining_q - CFG_DWIDTH'(chunk_iss);
                    state_d     = (remaining_d == '0) ? ST_DRAIN : ST_CALC;
                end
            end
            ST_DRAIN: begin
                if (credit_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            alen_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            alen_q      <= alen_d;
        end
    end

    axis_credit_cnt #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (handshake),
        .dec   (burst_retire),
        .full  (credit_full),
        .empty (credit_empty)
    );

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_done  = (state_q == ST_DONE);
    assign axi_aaddr = addr_q;
    assign axi_alen  = alen_q;

endmodule
